// File: rtl/uart_defs_pkg.sv
// Shared UART definitions: receiver FSM encoding, frame width and the
// oversampling divider calculation used by both receive and transmit sides.
package uart_defs_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    localparam int DATA_BITS = 8;

    function automatic int calc_ratio(input int clk_freq, input int baud_rate, input int sample_ratio);
        return clk_freq / baud_rate / sample_ratio;
    endfunction

endpackage

// File: rtl/baud_tick.sv
// Oversampling tick generator: one-clk enable every RATIO clks, restartable via clr.
module baud_tick #(
    parameter int RATIO = 651
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);
    localparam int CW = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic [CW-1:0] cnt_reg;

    assign tick = (cnt_reg == CW'(RATIO - 1));

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_reg <= '0;
        end else if (tick) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/serial_receiver.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// valid/ready output holding register with sticky overrun.
module serial_receiver
    import uart_defs_pkg::*;
#(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int BAUD_RATE    = 9600,
    parameter int SAMPLE_RATIO = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dout,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       overrun
);
    localparam int SAMPLE_CLK_RATIO = calc_ratio(CLK_FREQ, BAUD_RATE, SAMPLE_RATIO);
    localparam int M  = SAMPLE_RATIO / 2;
    localparam int PW = $clog2(SAMPLE_RATIO);
    localparam int BW = $clog2(DATA_BITS);

    logic                 rx_meta_reg;
    logic                 rx_s_reg;
    logic                 tick;
    logic                 clr;
    rx_state_t            state_reg;
    logic [PW-1:0]        phase_reg;
    logic [BW-1:0]        bit_idx_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 samp_a_reg;
    logic                 samp_b_reg;
    logic                 done_reg;
    logic                 frame_err_reg;
    logic [7:0]           dout_reg;
    logic                 valid_reg;
    logic                 overrun_reg;
    logic                 vote;
    logic                 decide;
    logic                 bit_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rx_s_reg    <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rx_s_reg    <= rx_meta_reg;
        end
    end

    // Realign the tick grid to the detected start edge.
    assign clr = (state_reg == IDLE) && tick && !rx_s_reg;

    baud_tick #(
        .RATIO(SAMPLE_CLK_RATIO)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .tick(tick)
    );

    assign vote    = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_s_reg) | (samp_b_reg & rx_s_reg);
    assign decide  = tick && (phase_reg == PW'(M + 1));
    assign bit_end = tick && (phase_reg == PW'(SAMPLE_RATIO - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            bit_idx_reg   <= '0;
            shift_reg     <= '0;
            samp_a_reg    <= 1'b1;
            samp_b_reg    <= 1'b1;
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            frame_err_reg <= 1'b0;
            if (tick && phase_reg == PW'(M - 1)) samp_a_reg <= rx_s_reg;
            if (tick && phase_reg == PW'(M))     samp_b_reg <= rx_s_reg;
            case (state_reg)
                IDLE: begin
                    if (tick && !rx_s_reg) begin
                        state_reg <= START;
                        phase_reg <= '0;
                    end
                end
                START: begin
                    if (decide && vote) begin
                        state_reg <= IDLE;
                        phase_reg <= '0;
                    end else if (bit_end) begin
                        state_reg   <= DATA;
                        phase_reg   <= '0;
                        bit_idx_reg <= '0;
                    end else if (tick) begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                DATA: begin
                    if (decide) shift_reg <= {vote, shift_reg[DATA_BITS-1:1]};
                    if (bit_end) begin
                        phase_reg   <= '0;
                        bit_idx_reg <= bit_idx_reg + 1'b1;
                        if (bit_idx_reg == BW'(DATA_BITS - 1)) state_reg <= STOP;
                    end else if (tick) begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge can be caught early.
                    if (decide) begin
                        done_reg      <= vote;
                        frame_err_reg <= !vote;
                        state_reg     <= IDLE;
                        phase_reg     <= '0;
                    end else if (tick) begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_reg    <= '0;
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end else if (done_reg) begin
            if (!valid_reg || ready) begin
                dout_reg  <= shift_reg;
                valid_reg <= 1'b1;
                if (valid_reg) overrun_reg <= 1'b0;
            end else begin
                overrun_reg <= 1'b1;
            end
        end else if (valid_reg && ready) begin
            valid_reg   <= 1'b0;
            overrun_reg <= 1'b0;
        end
    end

    assign dout      = dout_reg;
    assign valid     = valid_reg;
    assign frame_err = frame_err_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver at 160 clks per bit: frame table plus
// hand-written overrun and mid-frame reset sequences.
module tb_serial_receiver;

    localparam int BIT = 160;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] dout;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_errors = 0;
    int valid_cycles = 0;
    int ferr_cycles = 0;

    always #5 clk = ~clk;

    serial_receiver #(
        .CLK_FREQ    (1_600_000),
        .BAUD_RATE   (10_000),
        .SAMPLE_RATIO(16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .dout     (dout),
        .valid    (valid),
        .ready    (ready),
        .frame_err(frame_err),
        .overrun  (overrun)
    );

    always @(negedge clk) begin
        if (valid) valid_cycles <= valid_cycles + 1;
        if (frame_err) ferr_cycles <= ferr_cycles + 1;
    end

    typedef struct {
        logic [7:0] data;
        int         bit_clks;
        logic       stop_bit;
        logic       glitch_before;
        int         exp_valid_cycles;
        logic [7:0] exp_dout;
        int         exp_ferr_cycles;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive_line(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] data, input int bc, input logic stop_bit);
        drive_line(1'b0, bc);
        for (int i = 0; i < 8; i++) drive_line(data[i], bc);
        drive_line(stop_bit, bc);
        rx = 1'b1;
    endtask

    initial begin
        int v0, f0;

        vecs[0] = '{8'hA5, 160, 1'b1, 1'b0, 1, 8'hA5, 0};
        vecs[1] = '{8'h3C, 160, 1'b1, 1'b1, 1, 8'h3C, 0};
        vecs[2] = '{8'h55, 160, 1'b0, 1'b0, 0, 8'h3C, 1};
        vecs[3] = '{8'h00, 155, 1'b1, 1'b0, 1, 8'h00, 0};
        vecs[4] = '{8'hFF, 155, 1'b1, 1'b0, 1, 8'hFF, 0};
        vecs[5] = '{8'h00, 165, 1'b1, 1'b0, 1, 8'h00, 0};
        vecs[6] = '{8'hFF, 165, 1'b1, 1'b0, 1, 8'hFF, 0};

        repeat (5) @(negedge clk);
        rst = 1'b0;
        check("reset dout", dout, 0);
        check("reset valid", valid, 0);
        check("reset frame_err", frame_err, 0);
        check("reset overrun", overrun, 0);
        $display("reset: dout=%0h valid=%0b frame_err=%0b overrun=%0b", dout, valid, frame_err, overrun);
        repeat (2 * BIT) @(negedge clk);

        for (int k = 0; k < 7; k++) begin
            if (vecs[k].glitch_before) begin
                v0 = valid_cycles;
                f0 = ferr_cycles;
                drive_line(1'b0, 30);
                drive_line(1'b1, 3 * BIT);
                check("glitch valid", valid_cycles - v0, 0);
                check("glitch frame_err", ferr_cycles - f0, 0);
                $display("glitch: valid_cycles=%0d ferr_cycles=%0d", valid_cycles - v0, ferr_cycles - f0);
            end
            v0 = valid_cycles;
            f0 = ferr_cycles;
            send_frame(vecs[k].data, vecs[k].bit_clks, vecs[k].stop_bit);
            drive_line(1'b1, 2 * BIT);
            check($sformatf("vec%0d valid cycles", k), valid_cycles - v0, vecs[k].exp_valid_cycles);
            check($sformatf("vec%0d dout", k), dout, vecs[k].exp_dout);
            check($sformatf("vec%0d frame_err cycles", k), ferr_cycles - f0, vecs[k].exp_ferr_cycles);
            check($sformatf("vec%0d overrun", k), overrun, 0);
            $display("vec%0d: sent=%0h bit=%0d stop=%0b -> dout=%0h valid_cycles=%0d ferr_cycles=%0d",
                     k, vecs[k].data, vecs[k].bit_clks, vecs[k].stop_bit, dout,
                     valid_cycles - v0, ferr_cycles - f0);
        end

        // Overrun: two frames with no consumer
        ready = 1'b0;
        send_frame(8'h11, BIT, 1'b1);
        send_frame(8'h22, BIT, 1'b1);
        drive_line(1'b1, 2 * BIT);
        check("overrun dout", dout, 8'h11);
        check("overrun valid", valid, 1);
        check("overrun flag", overrun, 1);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
        check("drain valid", valid, 0);
        check("drain overrun", overrun, 0);
        drive_line(1'b1, 2 * BIT);
        check("dropped byte absent valid", valid, 0);
        check("dropped byte absent dout", dout, 8'h11);
        $display("overrun: dout=%0h valid=%0b overrun=%0b", dout, valid, overrun);
        ready = 1'b1;

        // Reset halfway through data bit 4 of 0xFF
        f0 = ferr_cycles;
        drive_line(1'b0, BIT);
        drive_line(1'b1, 4 * BIT + BIT / 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midreset dout", dout, 0);
        check("midreset valid", valid, 0);
        check("midreset frame_err", frame_err, 0);
        check("midreset overrun", overrun, 0);
        drive_line(1'b1, 4 * BIT + BIT / 2);
        drive_line(1'b1, 2 * BIT);
        v0 = valid_cycles;
        send_frame(8'h81, BIT, 1'b1);
        drive_line(1'b1, 2 * BIT);
        check("post-reset valid cycles", valid_cycles - v0, 1);
        check("post-reset dout", dout, 8'h81);
        check("post-reset frame_err", ferr_cycles - f0, 0);
        $display("midreset: next frame dout=%0h valid_cycles=%0d", dout, valid_cycles - v0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_receiver.md
Name: serial_receiver

Overview:
- UART receive front end: recovers 8N1 bytes from the asynchronous serial line and hands them downstream over a valid/ready handshake.
- Sits directly upstream of the serial transceiver's processing path and consumes its `din` line.
- Single 100 MHz clock domain; uses a 16x oversampling tick enable, not a derived clock.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, line bit rate.
- SAMPLE_RATIO, 16, oversampling ticks per bit (minimum 8).
- SAMPLE_CLK_RATIO (localparam), CLK_FREQ/BAUD_RATE/SAMPLE_RATIO, which gives 651 at the defaults.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- dout  output  8  received byte; stable while valid=1.
- valid  output  1  dout holds an unconsumed byte.
- ready  input  1  downstream accepts dout when valid&ready at a clk edge.
- frame_err  output  1  one-clk pulse: stop bit sampled low.
- overrun  output  1  sticky: a completed byte was dropped because valid was still 1.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values:
  - dout=0, valid=0, frame_err=0, overrun=0.
  - FSM=IDLE; tick and phase counters 0.
  - rx synchroniser flops=1.
- rx synchroniser: 2-flop synchroniser; all logic uses the synchronised rx_s (2-clk latency).
- Tick generator:
  - Counter 0..SAMPLE_CLK_RATIO-1, free-running.
  - tick=1 for one clk when the counter equals SAMPLE_CLK_RATIO-1.
  - Counter is reloaded to 0 on entry to START.
- Phase counter: 0..SAMPLE_RATIO-1, advances on tick.
- Sampling: bit value = majority of rx_s at phases M-1, M and M+1, where M=SAMPLE_RATIO/2. The decision is made at the tick of phase M+1.
- FSM transitions:
  - IDLE: on a tick with rx_s=0 -> START, phase=0.
  - START: at the decision point, vote=1 -> IDLE (false start, nothing reported). Otherwise continue to the phase SAMPLE_RATIO-1 tick -> DATA, bit index=0, phase=0.
  - DATA: the decided bit is shifted in LSB first. At the phase SAMPLE_RATIO-1 tick, the bit index increments. After bit 7 -> STOP.
  - STOP:
    - At the decision point, vote=1 -> byte complete.
    - vote=0 -> frame_err pulses for exactly one clk and the byte is discarded.
    - Either way -> IDLE immediately after the decision; do not wait for the bit end. This gives resync margin.
- Byte-complete rules, registered (valid/dout update on the clk after the decision):
  - valid=0 -> dout<=byte, valid<=1.
  - valid=1 and ready=1 in the same clk -> dout<=new byte, valid stays 1, no overrun.
  - valid=1 and ready=0 -> new byte dropped, dout unchanged, overrun<=1.
- Handshake:
  - valid&ready with no completion in that clk -> valid<=0.
  - dout is held while valid=1.
  - overrun clears only on the next valid&ready transfer or on rst.
- Framing: a frame error never affects valid/dout/overrun.
- Mid-frame reset: rst in any state returns everything to the reset values next clk; the partial byte is lost. A line still low after reset is treated as a start bit only when rx_s is 0 at an IDLE tick.
- Tolerance: must receive correctly at ±3% baud mismatch at the defaults.

Decomposition:
- Shared package/include uart_defs:
  - FSM state encodings IDLE/START/DATA/STOP (2 bits).
  - DATA_BITS=8.
  - Ratio computation macro, reused by the transmitter side.
- One sub-module, baud_tick:
  - Parameter RATIO; ports clk, rst, clr, tick.
  - Single-clk enable pulse every RATIO clks.
- Synchroniser, vote, FSM and handshake remain in serial_receiver.

Test Plan:
Simulation override: CLK_FREQ=1_600_000, BAUD_RATE=10_000, so SAMPLE_CLK_RATIO=10 and 160 clks per bit.
1. Frame 0xA5 (start 0, bits 1,0,1,0,0,1,0,1 LSB first, stop 1), ready=1 -> valid pulses 1 clk with dout=0xA5; frame_err=0, overrun=0.
2. rx low for 30 clks then high (glitch) -> no valid, no frame_err, FSM back in IDLE; next frame 0x3C -> dout=0x3C.
3. Frame 0x55 with stop bit 0 -> frame_err high exactly 1 clk; valid stays 0; dout unchanged.
4. ready=0; back-to-back frames 0x11 then 0x22 -> dout=0x11, valid=1, overrun=1. Raise ready 1 clk -> valid=0, overrun=0, and 0x22 is never presented.
5. Assert rst for 1 clk mid-way through data bit 4 of frame 0xFF -> all outputs 0 next clk; the following clean frame 0x81 is received as 0x81.
6. Frames 0x00 and 0xFF sent at baud +3% and -3% (155/165 clks per bit) -> each received correctly with no frame_err.
